// File: rtl/cic_decim_sequencer.sv
// Strobe sequencer for a decimating CIC filter: rate counter, comb-stage strobe delay line,
// PRIME flush of stale comb history and output handshake. Optional macro CIC_SEQ_OVERRUN_CNT_EN.
module cic_decim_sequencer #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned RATE_W = 12
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_strobe,
    input  logic [RATE_W-1:0] rate,
    input  logic              rate_load,
    output logic [STAGES-1:0] comb_strobe,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic [7:0]        overrun_cnt,
    output logic [1:0]        state
);
    localparam int unsigned DW = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W-1:0] r_q, r_d;
    logic [RATE_W-1:0] pend_rate_q, pend_rate_d;
    logic              pend_q, pend_d;
    logic [DW-1:0]     disc_q, disc_d;
    logic [STAGES-1:0] cs_q, cs_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              boundary_c, end_c, ovr_event_c;
    logic [RATE_W-1:0] rate_clamped_c;

    assign rate_clamped_c = (rate < RATE_W'(2)) ? RATE_W'(2) : rate;
    assign boundary_c     = (state_q != IDLE) && in_strobe && (cnt_q == r_q - RATE_W'(1));
    assign end_c          = cs_q[STAGES-1];

    // State register and all registered outputs
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= RATE_W'(2);
            pend_rate_q <= '0;
            pend_q      <= 1'b0;
            disc_q      <= '0;
            cs_q        <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            pend_rate_q <= pend_rate_d;
            pend_q      <= pend_d;
            disc_q      <= disc_d;
            cs_q        <= cs_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state, counter, delay line and handshake logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        pend_rate_d = pend_rate_q;
        pend_d      = pend_q;
        disc_d      = disc_q;
        valid_d     = valid_q;
        ovr_event_c = 1'b0;
        cs_d        = (cs_q << 1) | STAGES'(boundary_c);

        if (boundary_c) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && in_strobe) begin
            cnt_d = cnt_q + RATE_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rate_load) begin
                    r_d     = rate_clamped_c;
                    cnt_d   = '0;
                    disc_d  = '0;
                    valid_d = 1'b0;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (end_c) begin
                    if (disc_q == DW'(STAGES - 1)) begin
                        disc_d  = '0;
                        state_d = RUN;
                    end else begin
                        disc_d = disc_q + DW'(1);
                    end
                end
            end
            RUN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                end
                if (end_c) begin
                    ovr_event_c = valid_q && !out_ready;
                    valid_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pending rate takes effect only at a boundary; a load in the same cycle waits for the next one
        if (state_q != IDLE) begin
            if (boundary_c && pend_q) begin
                r_d         = pend_rate_q;
                pend_d      = 1'b0;
                disc_d      = '0;
                valid_d     = 1'b0;
                ovr_event_c = 1'b0;
                state_d     = PRIME;
            end
            if (rate_load) begin
                pend_d      = 1'b1;
                pend_rate_d = rate_clamped_c;
            end
        end

        ovr_d = ovr_event_c;
    end

`ifdef CIC_SEQ_OVERRUN_CNT_EN
    logic [7:0] ocnt_q;

    // Saturating overrun event counter
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ocnt_q <= 8'd0;
        end else if (ovr_event_c && (ocnt_q != 8'hFF)) begin
            ocnt_q <= ocnt_q + 8'd1;
        end
    end

    assign overrun_cnt = ocnt_q;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign comb_strobe = cs_q;
    assign out_valid   = valid_q;
    assign overrun     = ovr_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Directed self-checking bench for cic_decim_sequencer (STAGES=5, RATE_W=12).
module tb_cic_decim_sequencer;
`ifdef CIC_SEQ_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_n;
    logic        in_strobe;
    logic [11:0] rate;
    logic        rate_load;
    logic [4:0]  comb_strobe;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic [7:0]  overrun_cnt;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    cic_decim_sequencer #(.STAGES(5), .RATE_W(12)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .in_strobe   (in_strobe),
        .rate        (rate),
        .rate_load   (rate_load),
        .comb_strobe (comb_strobe),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        in_strobe = 1'b0;
        rate_load = 1'b0;
        rate      = 12'd0;
        out_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic load_rate(input logic [11:0] r);
        rate      = r;
        rate_load = 1'b1;
        tick;
        rate_load = 1'b0;
    endtask

    // Boundary edges for the rate-change scenario: R=8 up to edge 88, then R=16
    function automatic bit bnd_rc(input int m);
        if (m >= 8 && m <= 88) return (m % 8) == 0;
        if (m > 88) return ((m - 88) % 16) == 0;
        return 1'b0;
    endfunction

    task automatic test_reset;
        do_reset;
        checks++;
        if (state !== 2'd0 || comb_strobe !== 5'd0 || out_valid !== 1'b0 ||
            overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d cs=%b v=%b ovr=%b cnt=%0d, want 0/0/0/0/0",
                     state, comb_strobe, out_valid, overrun, overrun_cnt);
        end
        in_strobe = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick;
            checks++;
            if (comb_strobe !== 5'd0 || state !== 2'd0) begin
                errors++;
                $display("FAIL idle_ignore n=%0d: cs=%b state=%0d, want 0/0", n, comb_strobe, state);
            end
        end
    endtask

    task automatic test_rate4;
        logic [4:0] exp_cs;
        logic [1:0] exp_st;
        logic       exp_v;
        do_reset;
        in_strobe = 1'b1;
        load_rate(12'd4);
        for (int n = 1; n <= 40; n++) begin
            tick;
            exp_cs = '0;
            for (int k = 0; k < 5; k++)
                if (n - k >= 4 && ((n - k) % 4) == 0) exp_cs[k] = 1'b1;
            exp_st = (n < 25) ? 2'd1 : 2'd2;
            exp_v  = (n >= 29) && ((n % 4) == 1);
            checks++;
            if (comb_strobe !== exp_cs || state !== exp_st || out_valid !== exp_v) begin
                errors++;
                $display("FAIL rate4 n=%0d: cs=%b st=%0d v=%b, want cs=%b st=%0d v=%b",
                         n, comb_strobe, state, out_valid, exp_cs, exp_st, exp_v);
            end
        end
    endtask

    task automatic test_rate0_clamp;
        do_reset;
        load_rate(12'd0);
        for (int n = 1; n <= 16; n++) begin
            in_strobe = (n % 2) == 1;
            tick;
            checks++;
            if (comb_strobe[0] !== ((n % 4) == 3) || state !== 2'd1) begin
                errors++;
                $display("FAIL rate0_clamp n=%0d: cs0=%b st=%0d, want cs0=%b st=1",
                         n, comb_strobe[0], state, (n % 4) == 3);
            end
        end
    endtask

    task automatic test_overrun;
        logic       exp_v, exp_o;
        logic [7:0] exp_c;
        logic [1:0] exp_st;
        do_reset;
        in_strobe = 1'b1;
        load_rate(12'd8);
        for (int n = 1; n <= 78; n++) begin
            out_ready = !(n >= 53 && n <= 76);
            tick;
            exp_v  = (n >= 53) && (n <= 77);
            exp_o  = (n == 61) || (n == 69);
            exp_c  = !CNT_EN ? 8'd0 : (n >= 69) ? 8'd2 : (n >= 61) ? 8'd1 : 8'd0;
            exp_st = (n < 45) ? 2'd1 : 2'd2;
            checks++;
            if (out_valid !== exp_v || overrun !== exp_o || overrun_cnt !== exp_c || state !== exp_st) begin
                errors++;
                $display("FAIL overrun n=%0d: v=%b o=%b cnt=%0d st=%0d, want v=%b o=%b cnt=%0d st=%0d",
                         n, out_valid, overrun, overrun_cnt, state, exp_v, exp_o, exp_c, exp_st);
            end
        end
    endtask

    task automatic test_rate_change;
        logic [4:0] exp_cs;
        logic [1:0] exp_st;
        logic       exp_v;
        do_reset;
        in_strobe = 1'b1;
        load_rate(12'd8);
        for (int n = 1; n <= 175; n++) begin
            rate      = 12'd16;
            rate_load = (n == 84);
            tick;
            rate_load = 1'b0;
            exp_cs = '0;
            for (int k = 0; k < 5; k++)
                if (n - k >= 1 && bnd_rc(n - k)) exp_cs[k] = 1'b1;
            exp_st = (n < 45) ? 2'd1 : (n < 88) ? 2'd2 : (n < 157) ? 2'd1 : 2'd2;
            exp_v  = (n < 88) ? ((n >= 53) && ((n % 8) == 5)) : (n == 173);
            checks++;
            if (comb_strobe !== exp_cs || state !== exp_st || out_valid !== exp_v) begin
                errors++;
                $display("FAIL rate_change n=%0d: cs=%b st=%0d v=%b, want cs=%b st=%0d v=%b",
                         n, comb_strobe, state, out_valid, exp_cs, exp_st, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        in_strobe = 1'b1;
        load_rate(12'd4);
        for (int n = 1; n <= 6; n++) tick;
        checks++;
        if (comb_strobe !== 5'b00100) begin
            errors++;
            $display("FAIL reset_mid_pre: cs=%b, want 00100", comb_strobe);
        end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if (comb_strobe !== 5'd0 || state !== 2'd0 || overrun_cnt !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_in: cs=%b st=%0d cnt=%0d v=%b, want 0/0/0/0",
                     comb_strobe, state, overrun_cnt, out_valid);
        end
        for (int n = 8; n <= 12; n++) begin
            tick;
            checks++;
            if (comb_strobe !== 5'd0 || state !== 2'd0) begin
                errors++;
                $display("FAIL reset_mid_post n=%0d: cs=%b st=%0d, want 0/0", n, comb_strobe, state);
            end
        end
    endtask

    task automatic test_saturate;
        int pulses = 0;
        do_reset;
        in_strobe = 1'b1;
        out_ready = 1'b0;
        load_rate(12'd0);
        for (int n = 1; n <= 640; n++) begin
            tick;
            if (overrun === 1'b1) pulses++;
            checks++;
            if (overrun !== ((n >= 19) && ((n % 2) == 1))) begin
                errors++;
                $display("FAIL sat_pulse n=%0d: ovr=%b, want %b", n, overrun, (n >= 19) && ((n % 2) == 1));
            end
            if (n == 525) begin
                checks++;
                if (overrun_cnt !== (CNT_EN ? 8'd254 : 8'd0)) begin
                    errors++;
                    $display("FAIL sat_cnt_254: cnt=%0d, want %0d", overrun_cnt, CNT_EN ? 254 : 0);
                end
            end
        end
        checks++;
        if (overrun_cnt !== (CNT_EN ? 8'd255 : 8'd0) || pulses != 311) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d pulses=%0d, want cnt=%0d pulses=311",
                     overrun_cnt, pulses, CNT_EN ? 255 : 0);
        end
    endtask

    initial begin
        test_reset;
        test_rate4;
        test_rate0_clamp;
        test_overrun;
        test_rate_change;
        test_reset_mid;
        test_saturate;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
